// File: rtl/uart_tx_fifo.sv
// UART transmitter with configurable frame format and an integrated transmit FIFO.
// Defining UART_TX_BREAK_EN adds an i_Break input that holds the idle line low.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic                          i_TX_DV,
    input  logic [DATA_BITS-1:0]          i_TX_Byte,
`ifdef UART_TX_BREAK_EN
    input  logic                          i_Break,
`endif
    output logic                          o_TX_Ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_Count,
    output logic                          o_TX_Active,
    output logic                          o_TX_Serial,
    output logic                          o_TX_Done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_CLK   = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_DATA  = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] LAST_STOP  = IW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
    logic [AW:0]          r_count;
    state_t               r_state, w_next_state;
    logic [CW-1:0]        r_clk_cnt;
    logic [IW-1:0]        r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parity;
    logic                 r_done;
    logic                 w_push, w_pop, w_fifo_empty, w_bit_end, w_frame_end;
    logic                 w_can_start, w_cnt_run, w_break_line;
    logic [DATA_BITS-1:0] w_head;

    assign o_TX_Ready   = (r_count != FULL_COUNT);
    assign o_FIFO_Count = r_count;
    assign o_TX_Done    = r_done;
    assign w_push       = i_TX_DV && o_TX_Ready;
    assign w_fifo_empty = (r_count == '0);
    assign w_head       = r_mem[r_rd_ptr];
    assign w_bit_end    = (r_clk_cnt == LAST_CLK);

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is left unreset; the pointers and count alone define which entries are valid.
    always_ff @(posedge i_Clock) begin
        if (w_push) r_mem[r_wr_ptr] <= i_TX_Byte;
    end

`ifdef UART_TX_BREAK_EN
    // r_hold marks the one-bit-time mark that must follow a break before the next start bit.
    logic r_hold;
    assign w_can_start  = !i_Break && (!r_hold || w_bit_end);
    assign w_cnt_run    = r_hold && !i_Break;
    assign w_break_line = i_Break;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_hold <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (i_Break)        r_hold <= 1'b1;
            else if (w_bit_end) r_hold <= 1'b0;
        end
    end
`else
    assign w_can_start  = 1'b1;
    assign w_cnt_run    = 1'b0;
    assign w_break_line = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_frame_end  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_fifo_empty && w_can_start) begin
                    w_pop        = 1'b1;
                    w_next_state = S_START;
                end
            end
            S_START:  if (w_bit_end) w_next_state = S_DATA;
            S_DATA: begin
                if (w_bit_end && r_bit_idx == LAST_DATA)
                    w_next_state = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: if (w_bit_end) w_next_state = S_STOP;
            S_STOP: begin
                if (w_bit_end && r_bit_idx == LAST_STOP) begin
                    w_frame_end = 1'b1;
                    if (!w_fifo_empty && w_can_start) begin
                        w_pop        = 1'b1;
                        w_next_state = S_START;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= w_frame_end;
            if (w_pop) begin
                r_shift  <= w_head;
                r_parity <= (^w_head) ^ (PARITY_MODE == 2);
            end else if (r_state == S_DATA && w_bit_end) begin
                r_shift <= r_shift >> 1;
            end
            if (w_bit_end || (r_state == S_IDLE && !w_cnt_run)) r_clk_cnt <= '0;
            else                                                r_clk_cnt <= r_clk_cnt + 1'b1;
            if (w_next_state != r_state) r_bit_idx <= '0;
            else if (w_bit_end)          r_bit_idx <= r_bit_idx + 1'b1;
        end
    end

    always_comb begin
        o_TX_Serial = 1'b1;
        o_TX_Active = 1'b1;
        case (r_state)
            S_IDLE: begin
                o_TX_Serial = !w_break_line;
                o_TX_Active = 1'b0;
            end
            S_START:  o_TX_Serial = 1'b0;
            S_DATA:   o_TX_Serial = r_shift[0];
            S_PARITY: o_TX_Serial = r_parity;
            S_STOP:   o_TX_Serial = 1'b1;
            default:  o_TX_Active = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three frame formats against a queue-based waveform model,
// plus directed literal checks; define UART_TX_BREAK_EN to also cover the break input.
module tb_uart_tx_fifo;
    localparam int N = 3;
    localparam int CPB   [N] = '{4, 3, 2};
    localparam int DB    [N] = '{8, 7, 7};
    localparam int PM    [N] = '{0, 1, 2};
    localparam int SB    [N] = '{1, 2, 1};
    localparam int DEPTH [N] = '{4, 2, 4};

    logic clk = 1'b0;
    logic [N-1:0] rst, dv;
    logic [8:0]   byt [N];
    logic [N-1:0] ready, active, serial, done;
    logic [2:0]   cnt0, cnt2;
    logic [1:0]   cnt1;
`ifdef UART_TX_BREAK_EN
    logic [N-1:0] brk;
`endif

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut0 (
        .i_Clock(clk), .i_Reset(rst[0]), .i_TX_DV(dv[0]), .i_TX_Byte(byt[0][7:0]),
`ifdef UART_TX_BREAK_EN
        .i_Break(brk[0]),
`endif
        .o_TX_Ready(ready[0]), .o_FIFO_Count(cnt0), .o_TX_Active(active[0]),
        .o_TX_Serial(serial[0]), .o_TX_Done(done[0]));

    uart_tx_fifo #(.CLKS_PER_BIT(3), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2), .FIFO_DEPTH(2)) u_dut1 (
        .i_Clock(clk), .i_Reset(rst[1]), .i_TX_DV(dv[1]), .i_TX_Byte(byt[1][6:0]),
`ifdef UART_TX_BREAK_EN
        .i_Break(brk[1]),
`endif
        .o_TX_Ready(ready[1]), .o_FIFO_Count(cnt1), .o_TX_Active(active[1]),
        .o_TX_Serial(serial[1]), .o_TX_Done(done[1]));

    uart_tx_fifo #(.CLKS_PER_BIT(2), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut2 (
        .i_Clock(clk), .i_Reset(rst[2]), .i_TX_DV(dv[2]), .i_TX_Byte(byt[2][6:0]),
`ifdef UART_TX_BREAK_EN
        .i_Break(brk[2]),
`endif
        .o_TX_Ready(ready[2]), .o_FIFO_Count(cnt2), .o_TX_Active(active[2]),
        .o_TX_Serial(serial[2]), .o_TX_Done(done[2]));

    task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d: got %0h, expected %0h (t=%0t)", name, inst, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_cnt(int i);
        case (i)
            0:       return 32'(cnt0);
            1:       return 32'(cnt1);
            default: return 32'(cnt2);
        endcase
    endfunction

    // Model: FIFO as a queue of words, the frame in flight as the queue of line levels still to come.
    logic [8:0] m_fifo  [N][$];
    bit         m_frame [N][$];
    bit         m_done  [N];
`ifdef UART_TX_BREAK_EN
    int         m_hold  [N];
`endif

    function automatic logic [8:0] data_mask(int i);
        return 9'((1 << DB[i]) - 1);
    endfunction

    function automatic void load_frame(int i, logic [8:0] d);
        bit par;
        m_frame[i].delete();
        repeat (CPB[i]) m_frame[i].push_back(1'b0);
        for (int b = 0; b < DB[i]; b++) repeat (CPB[i]) m_frame[i].push_back(d[b]);
        if (PM[i] != 0) begin
            par = ^d;
            if (PM[i] == 2) par = !par;
            repeat (CPB[i]) m_frame[i].push_back(par);
        end
        repeat (SB[i] * CPB[i]) m_frame[i].push_back(1'b1);
    endfunction

    function automatic bit exp_serial(int i);
        if (m_frame[i].size() != 0) return m_frame[i][0];
`ifdef UART_TX_BREAK_EN
        if (brk[i]) return 1'b0;
`endif
        return 1'b1;
    endfunction

    // Compare this cycle's outputs with the model, then advance the model using this cycle's inputs.
    always @(negedge clk) begin : compare_and_model
        int         n;
        bit         pop, ok;
        logic [8:0] d;
        for (int i = 0; i < N; i++) begin
            if (cmp_en) begin
                check("serial", i, 32'(serial[i]), 32'(exp_serial(i)));
                check("active", i, 32'(active[i]), 32'(m_frame[i].size() != 0));
                check("done",   i, 32'(done[i]),   32'(m_done[i]));
                check("count",  i, dut_cnt(i),     32'(m_fifo[i].size()));
                check("ready",  i, 32'(ready[i]),  32'(m_fifo[i].size() != DEPTH[i]));
            end
            if (rst[i]) begin
                m_fifo[i].delete();
                m_frame[i].delete();
                m_done[i] = 1'b0;
`ifdef UART_TX_BREAK_EN
                m_hold[i] = 0;
`endif
            end else begin
                n         = m_fifo[i].size();
                m_done[i] = 1'b0;
                pop       = 1'b0;
                ok        = 1'b1;
                if (m_frame[i].size() == 0) begin
`ifdef UART_TX_BREAK_EN
                    if (brk[i]) begin
                        m_hold[i] = CPB[i];
                        ok = 1'b0;
                    end else if (m_hold[i] > 0) begin
                        m_hold[i]--;
                        ok = (m_hold[i] == 0);
                    end
`endif
                    pop = (n != 0) && ok;
                end else begin
                    if (m_frame[i].size() == 1) begin
                        m_done[i] = 1'b1;
`ifdef UART_TX_BREAK_EN
                        ok = !brk[i];
`endif
                        pop = (n != 0) && ok;
                    end
                    void'(m_frame[i].pop_front());
                end
                if (dv[i] && n != DEPTH[i]) m_fifo[i].push_back(byt[i] & data_mask(i));
                if (pop) begin
                    d = m_fifo[i].pop_front();
                    load_frame(i, d);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [9:0] bits;
    int         done_c, done_c2, n_done, n_act, n_low, n_high, n_nrdy;
    logic       par1, par2;

    initial begin
        rst = '1;
        dv  = '0;
        byt = '{default: '0};
`ifdef UART_TX_BREAK_EN
        brk = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst    = '0;
        cmp_en = 1'b1;

        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check("rst_serial", i, 32'(serial[i]), 1);
            check("rst_active", i, 32'(active[i]), 0);
            check("rst_ready",  i, 32'(ready[i]),  1);
            check("rst_count",  i, dut_cnt(i),     0);
        end
        next_cycle();

        // 8N1 0x55: start edge two cycles after the write, done 40 cycles after the edge.
        bits = '0; done_c = -1; n_done = 0;
        for (int c = 0; c < 50; c++) begin
            dv[0] = (c == 0); byt[0] = 9'h055;
            @(negedge clk);
            if (c == 1) check("t1_before_start", 0, 32'(serial[0]), 1);
            if (c == 2) check("t1_start_edge",   0, 32'(serial[0]), 0);
            if (c >= 4 && c < 44 && (c % 4) == 0) bits[(c - 4) / 4] = serial[0];
            if (done[0]) begin n_done++; if (done_c < 0) done_c = c; end
            next_cycle();
        end
        check("t1_frame_bits", 0, 32'(bits), 32'h2AA);
        check("t1_done_cycle", 0, done_c, 42);
        check("t1_done_count", 0, n_done, 1);

        // 0x07 in 7E2 (parity 1) and 7O1 (parity 0, 10-bit frame).
        done_c = -1; done_c2 = -1; par1 = 1'bx; par2 = 1'bx;
        for (int c = 0; c < 45; c++) begin
            dv[1] = (c == 0); dv[2] = (c == 0); byt[1] = 9'h007; byt[2] = 9'h007;
            @(negedge clk);
            if (c == 27) par1 = serial[1];
            if (c == 19) par2 = serial[2];
            if (done[1] && done_c < 0)  done_c  = c;
            if (done[2] && done_c2 < 0) done_c2 = c;
            next_cycle();
        end
        check("t2_even_parity", 1, 32'(par1), 1);
        check("t2_odd_parity",  2, 32'(par2), 0);
        check("t2_7e2_done",    1, done_c,  35);
        check("t2_7o1_done",    2, done_c2, 22);

        // Three back-to-back frames with no idle gap.
        n_done = 0; n_act = 0; done_c = -1;
        for (int c = 0; c < 130; c++) begin
            dv[0] = (c < 3); byt[0] = 9'(8'h41 + c);
            @(negedge clk);
            if (active[0]) n_act++;
            if (done[0]) begin n_done++; done_c = c; end
            if (c == 121) check("t3_active_last", 0, 32'(active[0]), 1);
            if (c == 122) check("t3_active_fall", 0, 32'(active[0]), 0);
            next_cycle();
        end
        check("t3_active_cycles", 0, n_act, 120);
        check("t3_done_count",    0, n_done, 3);
        check("t3_last_done",     0, done_c, 122);

        // Hold the write strobe for 8 cycles into a 4-deep FIFO.
        n_done = 0; n_nrdy = 0; done_c = -1;
        for (int c = 0; c < 215; c++) begin
            dv[0] = (c < 8); byt[0] = 9'(8'h10 + c);
            @(negedge clk);
            if (!ready[0]) n_nrdy++;
            if (done[0]) begin n_done++; done_c = c; end
            if (c == 8) begin
                check("t4_full_count", 0, dut_cnt(0), 4);
                check("t4_full_ready", 0, 32'(ready[0]), 0);
            end
            next_cycle();
        end
        check("t4_not_ready_cycles", 0, n_nrdy, 37);
        check("t4_frames_sent",      0, n_done, 5);
        check("t4_last_done",        0, done_c, 202);

        // Reset during data bit 3 with two words queued.
        n_done = 0; n_low = 0;
        for (int c = 0; c < 80; c++) begin
            dv[0] = (c < 3); byt[0] = 9'(8'h60 + c); rst[0] = (c == 19);
            @(negedge clk);
            if (done[0]) n_done++;
            if (c >= 20 && !serial[0]) n_low++;
            if (c == 20) begin
                check("t5_line_high", 0, 32'(serial[0]), 1);
                check("t5_count",     0, dut_cnt(0), 0);
                check("t5_active",    0, 32'(active[0]), 0);
            end
            next_cycle();
        end
        rst[0] = 1'b0;
        check("t5_no_done",   0, n_done, 0);
        check("t5_no_frames", 0, n_low, 0);

`ifdef UART_TX_BREAK_EN
        // Break for 20 cycles with a word queued, then one bit time of mark, then the frame.
        n_low = 0; n_high = 0; done_c = -1;
        for (int c = 0; c < 70; c++) begin
            brk[0] = (c < 20); dv[0] = (c == 0); byt[0] = 9'h0A5;
            @(negedge clk);
            if (c < 20 && !serial[0]) n_low++;
            if (c >= 20 && c < 24 && serial[0]) n_high++;
            if (c == 23) check("t6_inactive_mark", 0, 32'(active[0]), 0);
            if (c == 24) check("t6_start_bit",     0, 32'(serial[0]), 0);
            if (done[0] && done_c < 0) done_c = c;
            next_cycle();
        end
        check("t6_break_low", 0, n_low, 20);
        check("t6_mark_high", 0, n_high, 4);
        check("t6_done",      0, done_c, 64);
`endif

        // Randomised traffic on all three formats, alternating light and heavy load, rare resets.
        for (int c = 0; c < 2400; c++) begin
            for (int i = 0; i < N; i++) begin
                dv[i]  = ($urandom_range(0, 99) < (((c / 400) % 2 == 1) ? 70 : 12));
                byt[i] = 9'($urandom);
                rst[i] = ($urandom_range(0, 599) == 0);
            end
            next_cycle();
        end
        dv = '0; rst = '0;
        repeat (400) next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
